// File: rtl/anycore_l15_defs_pkg.sv
// anycore_l15_defs: encodings and helpers shared by the AnyCore <-> L1.5
// transducer (request-side decoder and response-side encoder).
//   - rqtype_e   : L1.5 request types issued by the decoder
//   - rettype_e  : L1.5 return packet types consumed by the encoder
//   - enc_state_e: encoder return FSM states
//   - bswap64    : 64-bit byte reversal (byte 0 <-> byte 7)
package anycore_l15_defs;

    localparam int unsigned L15_PHY_ADDR_WIDTH = 40;

    typedef enum logic [4:0] {
        LOAD_RQ  = 5'b00000,
        STORE_RQ = 5'b00001,
        IMISS_RQ = 5'b10000
    } rqtype_e;

    typedef enum logic [3:0] {
        LOAD_RET  = 4'b0000,
        IFILL_RET = 4'b0001,
        ST_ACK    = 4'b0100,
        INT_RET   = 4'b0111
    } rettype_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } enc_state_e;

    // L1.5 returns big-endian words; AnyCore expects little-endian bytes.
    function automatic logic [63:0] bswap64(input logic [63:0] d);
        return {d[7:0],   d[15:8],  d[23:16], d[31:24],
                d[39:32], d[47:40], d[55:48], d[63:56]};
    endfunction

endpackage

// File: rtl/anycore_req_tracker.sv
// anycore_req_tracker: snoops the decoder -> L1.5 request handshake and
// remembers at most one outstanding imiss, load and store.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_fire            decoder val & L1.5 ack this cycle
//   req_type/req_addr   request type and physical address
//   clr_imiss/load/store  return of that type captured this cycle
//   *_pend              outstanding flags
//   imiss_addr/load_addr  block address of the last imiss/load request
import anycore_l15_defs::*;

module anycore_req_tracker #(
    parameter int unsigned PHY_ADDR_WIDTH         = L15_PHY_ADDR_WIDTH,
    parameter int unsigned IC_OFFSET              = 5,
    parameter int unsigned DC_OFFSET              = 4,
    parameter int unsigned ICACHE_BLOCK_ADDR_BITS = PHY_ADDR_WIDTH - IC_OFFSET,
    parameter int unsigned DCACHE_BLOCK_ADDR_BITS = PHY_ADDR_WIDTH - DC_OFFSET
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_fire,
    input  logic [4:0]                        req_type,
    input  logic [PHY_ADDR_WIDTH-1:0]         req_addr,
    input  logic                              clr_imiss,
    input  logic                              clr_load,
    input  logic                              clr_store,
    output logic                              imiss_pend,
    output logic                              load_pend,
    output logic                              store_pend,
    output logic [ICACHE_BLOCK_ADDR_BITS-1:0] imiss_addr,
    output logic [DCACHE_BLOCK_ADDR_BITS-1:0] load_addr
);

    logic set_imiss;
    logic set_load;
    logic set_store;

    always_comb begin
        set_imiss = req_fire && (req_type == IMISS_RQ);
        set_load  = req_fire && (req_type == LOAD_RQ);
        set_store = req_fire && (req_type == STORE_RQ);
    end

    // A new request of a type wins over a same-cycle return of that type:
    // the return has already been handed the old address by the encoder.
    always_ff @(posedge clk) begin
        if (rst) begin
            imiss_pend <= 1'b0;
            load_pend  <= 1'b0;
            store_pend <= 1'b0;
            imiss_addr <= '0;
            load_addr  <= '0;
        end else begin
            if (set_imiss)      imiss_pend <= 1'b1;
            else if (clr_imiss) imiss_pend <= 1'b0;

            if (set_load)       load_pend <= 1'b1;
            else if (clr_load)  load_pend <= 1'b0;

            if (set_store)      store_pend <= 1'b1;
            else if (clr_store) store_pend <= 1'b0;

            if (set_imiss) imiss_addr <= ICACHE_BLOCK_ADDR_BITS'(req_addr >> IC_OFFSET);
            if (set_load)  load_addr  <= DCACHE_BLOCK_ADDR_BITS'(req_addr >> DC_OFFSET);
        end
    end

endmodule

// File: rtl/anycore_encoder.sv
// anycore_encoder: response-side adapter from L1.5 return packets to
// AnyCore refill/completion strobes.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   anycoredecoder_l15_*             snooped request (val/rqtype/address)
//   l15_transducer_ack               L1.5 accepted the snooped request
//   l15_transducer_val/returntype/data_0..3  return packet, held until acked
//   transducer_l15_req_ack           one-cycle pulse: return consumed
//   anycore_mem2ic_*                 I-cache fill strobe, block addr, line
//   anycore_mem2dc_ld*               D-cache load strobe, block addr, data
//   anycore_mem2dc_stcomplete        store-ack strobe
//   anycore_int                      interrupt-return strobe
//   anycore_encoder_err              sticky: return without matching request
import anycore_l15_defs::*;

module anycore_encoder #(
    parameter int unsigned IC_OFFSET              = 5,
    parameter int unsigned DC_OFFSET              = 4,
    parameter int unsigned IC_LINE_BITS           = 256,
    parameter int unsigned DC_LINE_BITS           = 128,
    parameter int unsigned PHY_ADDR_WIDTH         = L15_PHY_ADDR_WIDTH,
    parameter int unsigned ICACHE_BLOCK_ADDR_BITS = PHY_ADDR_WIDTH - IC_OFFSET,
    parameter int unsigned DCACHE_BLOCK_ADDR_BITS = PHY_ADDR_WIDTH - DC_OFFSET
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              anycoredecoder_l15_val,
    input  logic [4:0]                        anycoredecoder_l15_rqtype,
    input  logic [PHY_ADDR_WIDTH-1:0]         anycoredecoder_l15_address,
    input  logic                              l15_transducer_ack,
    input  logic                              l15_transducer_val,
    input  logic [3:0]                        l15_transducer_returntype,
    input  logic [63:0]                       l15_transducer_data_0,
    input  logic [63:0]                       l15_transducer_data_1,
    input  logic [63:0]                       l15_transducer_data_2,
    input  logic [63:0]                       l15_transducer_data_3,
    output logic                              transducer_l15_req_ack,
    output logic                              anycore_mem2ic_respvalid,
    output logic [ICACHE_BLOCK_ADDR_BITS-1:0] anycore_mem2ic_respaddr,
    output logic [IC_LINE_BITS-1:0]           anycore_mem2ic_data,
    output logic                              anycore_mem2dc_ldvalid,
    output logic [DCACHE_BLOCK_ADDR_BITS-1:0] anycore_mem2dc_ldaddr,
    output logic [DC_LINE_BITS-1:0]           anycore_mem2dc_lddata,
    output logic                              anycore_mem2dc_stcomplete,
    output logic                              anycore_int,
    output logic                              anycore_encoder_err
);

    enc_state_e state_q;
    logic       armed_q;

    logic capture;
    logic is_ifill;
    logic is_load;
    logic is_store;
    logic is_int;
    logic unmatched;

    logic                              imiss_pend;
    logic                              load_pend;
    logic                              store_pend;
    logic [ICACHE_BLOCK_ADDR_BITS-1:0] imiss_addr;
    logic [DCACHE_BLOCK_ADDR_BITS-1:0] load_addr;

    logic [IC_LINE_BITS-1:0] fill_data;
    logic [DC_LINE_BITS-1:0] load_data;

    anycore_req_tracker #(
        .PHY_ADDR_WIDTH         (PHY_ADDR_WIDTH),
        .IC_OFFSET              (IC_OFFSET),
        .DC_OFFSET              (DC_OFFSET),
        .ICACHE_BLOCK_ADDR_BITS (ICACHE_BLOCK_ADDR_BITS),
        .DCACHE_BLOCK_ADDR_BITS (DCACHE_BLOCK_ADDR_BITS)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .req_fire   (anycoredecoder_l15_val && l15_transducer_ack),
        .req_type   (anycoredecoder_l15_rqtype),
        .req_addr   (anycoredecoder_l15_address),
        .clr_imiss  (capture && is_ifill),
        .clr_load   (capture && is_load),
        .clr_store  (capture && is_store),
        .imiss_pend (imiss_pend),
        .load_pend  (load_pend),
        .store_pend (store_pend),
        .imiss_addr (imiss_addr),
        .load_addr  (load_addr)
    );

    always_comb begin
        is_ifill  = (l15_transducer_returntype == IFILL_RET);
        is_load   = (l15_transducer_returntype == LOAD_RET);
        is_store  = (l15_transducer_returntype == ST_ACK);
        is_int    = (l15_transducer_returntype == INT_RET);
        unmatched = (is_ifill && !imiss_pend) || (is_load && !load_pend) ||
                    (is_store && !store_pend);
        // armed_q blocks re-capturing a packet the L1.5 is still holding
        // after our ack; val must be seen low before the next capture.
        capture   = (state_q == S_IDLE) && l15_transducer_val && armed_q;
        fill_data = {bswap64(l15_transducer_data_3), bswap64(l15_transducer_data_2),
                     bswap64(l15_transducer_data_1), bswap64(l15_transducer_data_0)};
        load_data = {bswap64(l15_transducer_data_1), bswap64(l15_transducer_data_0)};
    end

    // Capture and output registration happen on the same edge so ack and
    // strobe appear the cycle after val is sampled; the ACK state only
    // retires the pulse and ignores val.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                   <= S_IDLE;
            armed_q                   <= 1'b1;
            transducer_l15_req_ack    <= 1'b0;
            anycore_mem2ic_respvalid  <= 1'b0;
            anycore_mem2ic_respaddr   <= '0;
            anycore_mem2ic_data       <= '0;
            anycore_mem2dc_ldvalid    <= 1'b0;
            anycore_mem2dc_ldaddr     <= '0;
            anycore_mem2dc_lddata     <= '0;
            anycore_mem2dc_stcomplete <= 1'b0;
            anycore_int               <= 1'b0;
            anycore_encoder_err       <= 1'b0;
        end else begin
            transducer_l15_req_ack    <= 1'b0;
            anycore_mem2ic_respvalid  <= 1'b0;
            anycore_mem2dc_ldvalid    <= 1'b0;
            anycore_mem2dc_stcomplete <= 1'b0;
            anycore_int               <= 1'b0;
            if (!l15_transducer_val) armed_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (capture) begin
                        state_q                   <= S_ACK;
                        armed_q                   <= 1'b0;
                        transducer_l15_req_ack    <= 1'b1;
                        anycore_mem2ic_respvalid  <= is_ifill;
                        anycore_mem2dc_ldvalid    <= is_load;
                        anycore_mem2dc_stcomplete <= is_store;
                        anycore_int               <= is_int;
                        if (is_ifill) begin
                            anycore_mem2ic_respaddr <= imiss_addr;
                            anycore_mem2ic_data     <= fill_data;
                        end
                        if (is_load) begin
                            anycore_mem2dc_ldaddr <= load_addr;
                            anycore_mem2dc_lddata <= load_data;
                        end
                        if (unmatched) anycore_encoder_err <= 1'b1;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_anycore_encoder.sv
module tb_anycore_encoder;
    import anycore_l15_defs::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         anycoredecoder_l15_val = 1'b0;
    logic [4:0]   anycoredecoder_l15_rqtype = '0;
    logic [39:0]  anycoredecoder_l15_address = '0;
    logic         l15_transducer_ack = 1'b0;
    logic         l15_transducer_val = 1'b0;
    logic [3:0]   l15_transducer_returntype = '0;
    logic [63:0]  l15_transducer_data_0 = '0;
    logic [63:0]  l15_transducer_data_1 = '0;
    logic [63:0]  l15_transducer_data_2 = '0;
    logic [63:0]  l15_transducer_data_3 = '0;
    logic         transducer_l15_req_ack;
    logic         anycore_mem2ic_respvalid;
    logic [34:0]  anycore_mem2ic_respaddr;
    logic [255:0] anycore_mem2ic_data;
    logic         anycore_mem2dc_ldvalid;
    logic [35:0]  anycore_mem2dc_ldaddr;
    logic [127:0] anycore_mem2dc_lddata;
    logic         anycore_mem2dc_stcomplete;
    logic         anycore_int;
    logic         anycore_encoder_err;

    always #5 clk = ~clk;

    anycore_encoder #(
        .IC_OFFSET      (5),
        .DC_OFFSET      (4),
        .IC_LINE_BITS   (256),
        .DC_LINE_BITS   (128),
        .PHY_ADDR_WIDTH (40)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .anycoredecoder_l15_val     (anycoredecoder_l15_val),
        .anycoredecoder_l15_rqtype  (anycoredecoder_l15_rqtype),
        .anycoredecoder_l15_address (anycoredecoder_l15_address),
        .l15_transducer_ack         (l15_transducer_ack),
        .l15_transducer_val         (l15_transducer_val),
        .l15_transducer_returntype  (l15_transducer_returntype),
        .l15_transducer_data_0      (l15_transducer_data_0),
        .l15_transducer_data_1      (l15_transducer_data_1),
        .l15_transducer_data_2      (l15_transducer_data_2),
        .l15_transducer_data_3      (l15_transducer_data_3),
        .transducer_l15_req_ack     (transducer_l15_req_ack),
        .anycore_mem2ic_respvalid   (anycore_mem2ic_respvalid),
        .anycore_mem2ic_respaddr    (anycore_mem2ic_respaddr),
        .anycore_mem2ic_data        (anycore_mem2ic_data),
        .anycore_mem2dc_ldvalid     (anycore_mem2dc_ldvalid),
        .anycore_mem2dc_ldaddr      (anycore_mem2dc_ldaddr),
        .anycore_mem2dc_lddata      (anycore_mem2dc_lddata),
        .anycore_mem2dc_stcomplete  (anycore_mem2dc_stcomplete),
        .anycore_int                (anycore_int),
        .anycore_encoder_err        (anycore_encoder_err)
    );

    // mask bits: {ack, int, stcomplete, ldvalid, ic respvalid}
    typedef struct {
        logic [4:0]   mask;
        logic [39:0]  addr;
        logic [255:0] data;
        logic         err;
        int           cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        ev_t e;
        if (transducer_l15_req_ack || anycore_mem2ic_respvalid || anycore_mem2dc_ldvalid ||
            anycore_mem2dc_stcomplete || anycore_int) begin
            e.mask = {transducer_l15_req_ack, anycore_int, anycore_mem2dc_stcomplete,
                      anycore_mem2dc_ldvalid, anycore_mem2ic_respvalid};
            e.addr = '0;
            e.data = '0;
            if (anycore_mem2ic_respvalid) begin
                e.addr = 40'(anycore_mem2ic_respaddr);
                e.data = anycore_mem2ic_data;
            end else if (anycore_mem2dc_ldvalid) begin
                e.addr = 40'(anycore_mem2dc_ldaddr);
                e.data = 256'(anycore_mem2dc_lddata);
            end
            e.err = anycore_encoder_err;
            e.cyc = cyc;
            obs_q.push_back(e);
        end
    end

    function automatic logic [63:0] ref_swap(input logic [63:0] w);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = w[8*(7-i) +: 8];
        return r;
    endfunction

    function automatic ev_t mk(input logic [4:0] m, input logic [39:0] a,
                               input logic [255:0] d, input logic e, input int c);
        ev_t x;
        x.mask = m; x.addr = a; x.data = d; x.err = e; x.cyc = c;
        return x;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic req(input logic [4:0] t, input logic [39:0] a);
        anycoredecoder_l15_val     = 1'b1;
        anycoredecoder_l15_rqtype  = t;
        anycoredecoder_l15_address = a;
        l15_transducer_ack         = 1'b1;
        step();
        anycoredecoder_l15_val = 1'b0;
        l15_transducer_ack     = 1'b0;
    endtask

    task automatic present(input logic [3:0] rt, input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [63:0] d3);
        l15_transducer_val        = 1'b1;
        l15_transducer_returntype = rt;
        l15_transducer_data_0     = d0;
        l15_transducer_data_1     = d1;
        l15_transducer_data_2     = d2;
        l15_transducer_data_3     = d3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        anycoredecoder_l15_val = 1'b0;
        l15_transducer_ack     = 1'b0;
        l15_transducer_val     = 1'b0;
        step(2);
        total++;
        if ({transducer_l15_req_ack, anycore_mem2ic_respvalid, anycore_mem2ic_respaddr,
             anycore_mem2ic_data, anycore_mem2dc_ldvalid, anycore_mem2dc_ldaddr,
             anycore_mem2dc_lddata, anycore_mem2dc_stcomplete, anycore_int,
             anycore_encoder_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ack=%b ic=%b ld=%b st=%b int=%b err=%b want all 0",
                     transducer_l15_req_ack, anycore_mem2ic_respvalid, anycore_mem2dc_ldvalid,
                     anycore_mem2dc_stcomplete, anycore_int, anycore_encoder_err);
        end
        rst = 1'b0;
        step();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_ifill();
        logic [63:0] d1, d2, d3;
        ev_t x, o;
        d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom}; d3 = {$urandom, $urandom};
        req(IMISS_RQ, 40'h0000_1040);
        present(IFILL_RET, 64'h0011223344556677, d1, d2, d3);
        exp_q.push_back(mk(5'b10001, 40'h82,
            {ref_swap(d3), ref_swap(d2), ref_swap(d1), ref_swap(64'h0011223344556677)}, 1'b0, cyc + 1));
        step();
        l15_transducer_val = 1'b0;
        step(3);
        total++;
        if (obs_q.size() != 1) begin
            bad++;
            $display("FAIL ifill_ack_count got=%0d want=1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            x = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.mask !== x.mask || o.cyc != x.cyc) begin
                bad++;
                $display("FAIL ifill_strobe got=%b@%0d want=%b@%0d", o.mask, o.cyc, x.mask, x.cyc);
            end
            total++;
            if (o.addr !== x.addr) begin
                bad++;
                $display("FAIL ifill_addr got=%h want=%h", o.addr, x.addr);
            end
            total++;
            if (o.data[63:0] !== 64'h7766554433221100) begin
                bad++;
                $display("FAIL ifill_word0 got=%h want=7766554433221100", o.data[63:0]);
            end
            total++;
            if (o.data !== x.data || o.err !== x.err) begin
                bad++;
                $display("FAIL ifill_line got=%h err=%b want=%h err=%b", o.data, o.err, x.data, x.err);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_load_hold();
        logic [63:0] d0, d1;
        ev_t x, o;
        d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
        req(LOAD_RQ, 40'h2010);
        present(LOAD_RET, d0, d1, '1, '1);
        exp_q.push_back(mk(5'b10010, 40'h201, {128'b0, ref_swap(d1), ref_swap(d0)}, 1'b0, cyc + 1));
        step(4);
        l15_transducer_val = 1'b0;
        step(3);
        total++;
        if (obs_q.size() != 1) begin
            bad++;
            $display("FAIL load_hold_count got=%0d want=1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            x = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.mask !== x.mask || o.cyc != x.cyc) begin
                bad++;
                $display("FAIL load_strobe got=%b@%0d want=%b@%0d", o.mask, o.cyc, x.mask, x.cyc);
            end
            total++;
            if (o.addr !== x.addr || o.data !== x.data || o.err !== x.err) begin
                bad++;
                $display("FAIL load_payload got addr=%h data=%h err=%b want addr=%h data=%h err=%b",
                         o.addr, o.data[127:0], o.err, x.addr, x.data[127:0], x.err);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_store();
        ev_t x, o;
        req(STORE_RQ, 40'h4000);
        present(ST_ACK, {$urandom, $urandom}, '0, '0, '0);
        exp_q.push_back(mk(5'b10100, '0, '0, 1'b0, cyc + 1));
        step();
        l15_transducer_val = 1'b0;
        step(3);
        total++;
        if (obs_q.size() != 1) begin
            bad++;
            $display("FAIL store_count got=%0d want=1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            x = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.mask !== x.mask || o.cyc != x.cyc || o.err !== x.err) begin
                bad++;
                $display("FAIL store_strobe got=%b@%0d err=%b want=%b@%0d err=%b",
                         o.mask, o.cyc, o.err, x.mask, x.cyc, x.err);
            end
        end
        total++;
        if (dut.u_tracker.store_pend !== 1'b0 || anycore_encoder_err !== 1'b0) begin
            bad++;
            $display("FAIL store_pending got pend=%b err=%b want pend=0 err=0",
                     dut.u_tracker.store_pend, anycore_encoder_err);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        ev_t x, o;
        present(INT_RET, '0, '0, '0, '0);
        exp_q.push_back(mk(5'b11000, '0, '0, 1'b0, cyc + 1));
        step();
        l15_transducer_val = 1'b0;
        step();
        present(4'hF, '0, '0, '0, '0);
        exp_q.push_back(mk(5'b10000, '0, '0, 1'b0, cyc + 1));
        step();
        l15_transducer_val = 1'b0;
        step(3);
        total++;
        if (obs_q.size() != 2) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=2", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            x = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.mask !== x.mask || o.cyc != x.cyc || o.err !== x.err) begin
                bad++;
                $display("FAIL b2b_strobe got=%b@%0d err=%b want=%b@%0d err=%b",
                         o.mask, o.cyc, o.err, x.mask, x.cyc, x.err);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_unmatched();
        logic [63:0] d0;
        ev_t x, o;
        d0 = {$urandom, $urandom};
        present(LOAD_RET, d0, '0, '0, '0);
        exp_q.push_back(mk(5'b10010, 40'h201, {192'b0, ref_swap(d0)}, 1'b1, cyc + 1));
        step();
        l15_transducer_val = 1'b0;
        step(4);
        total++;
        if (obs_q.size() != 1) begin
            bad++;
            $display("FAIL unmatched_count got=%0d want=1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            x = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.mask !== x.mask || o.cyc != x.cyc || o.addr !== x.addr ||
                o.data !== x.data || o.err !== x.err) begin
                bad++;
                $display("FAIL unmatched_event got=%b@%0d addr=%h err=%b want=%b@%0d addr=%h err=%b",
                         o.mask, o.cyc, o.addr, o.err, x.mask, x.cyc, x.addr, x.err);
            end
        end
        total++;
        if (anycore_encoder_err !== 1'b1) begin
            bad++;
            $display("FAIL unmatched_sticky got=%b want=1", anycore_encoder_err);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_same_cycle();
        logic [63:0] d0, d1;
        ev_t x, o;
        d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
        req(LOAD_RQ, 40'h2010);
        anycoredecoder_l15_val     = 1'b1;
        anycoredecoder_l15_rqtype  = LOAD_RQ;
        anycoredecoder_l15_address = 40'h3000;
        l15_transducer_ack         = 1'b1;
        present(LOAD_RET, d0, d1, '0, '0);
        exp_q.push_back(mk(5'b10010, 40'h201, {128'b0, ref_swap(d1), ref_swap(d0)}, 1'b0, cyc + 1));
        step();
        anycoredecoder_l15_val = 1'b0;
        l15_transducer_ack     = 1'b0;
        l15_transducer_val     = 1'b0;
        step();
        present(LOAD_RET, d1, d0, '0, '0);
        exp_q.push_back(mk(5'b10010, 40'h300, {128'b0, ref_swap(d0), ref_swap(d1)}, 1'b0, cyc + 1));
        step();
        l15_transducer_val = 1'b0;
        step(3);
        total++;
        if (obs_q.size() != 2) begin
            bad++;
            $display("FAIL same_cycle_count got=%0d want=2", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            x = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.mask !== x.mask || o.cyc != x.cyc || o.addr !== x.addr ||
                o.data !== x.data || o.err !== x.err) begin
                bad++;
                $display("FAIL same_cycle_event got=%b@%0d addr=%h err=%b want=%b@%0d addr=%h err=%b",
                         o.mask, o.cyc, o.addr, o.err, x.mask, x.cyc, x.addr, x.err);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_in_ack();
        ev_t x, o;
        req(IMISS_RQ, 40'h20_0000);
        present(IFILL_RET, 64'h1, 64'h2, 64'h3, 64'h4);
        exp_q.push_back(mk(5'b10001, 40'h1_0000,
            {ref_swap(64'h4), ref_swap(64'h3), ref_swap(64'h2), ref_swap(64'h1)}, 1'b0, cyc + 1));
        step();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            total++;
            if ({transducer_l15_req_ack, anycore_mem2ic_respvalid, anycore_mem2ic_respaddr,
                 anycore_mem2ic_data, anycore_mem2dc_ldvalid, anycore_mem2dc_ldaddr,
                 anycore_mem2dc_lddata, anycore_mem2dc_stcomplete, anycore_int,
                 anycore_encoder_err} !== '0) begin
                bad++;
                $display("FAIL reset_in_ack_%0d got ack=%b ic=%b err=%b want all 0",
                         k, transducer_l15_req_ack, anycore_mem2ic_respvalid, anycore_encoder_err);
            end
        end
        l15_transducer_val = 1'b0;
        rst = 1'b0;
        step(2);
        total++;
        if (obs_q.size() != 1) begin
            bad++;
            $display("FAIL reset_in_ack_count got=%0d want=1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            x = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.mask !== x.mask || o.cyc != x.cyc || o.addr !== x.addr || o.data !== x.data) begin
                bad++;
                $display("FAIL reset_in_ack_event got=%b@%0d addr=%h want=%b@%0d addr=%h",
                         o.mask, o.cyc, o.addr, x.mask, x.cyc, x.addr);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ifill();
        test_load_hold();
        test_store();
        test_back_to_back();
        test_unmatched();
        test_reset();
        test_same_cycle();
        test_reset_in_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/anycore_encoder.md
# anycore_encoder

Response-side adapter between the L1.5 and the AnyCore core: accepts L1.5 return packets (load data, instruction fill, store ack, interrupt), byte-swaps returned data into AnyCore order, re-associates each return with the block address of the outstanding request, and drives AnyCore's refill/completion strobes. It sits beside the request-side decoder in the L1.5 transducer. It snoops the decoder→L1.5 request handshake to track at most one outstanding imiss, one load and one store.

## Interface
- IC_OFFSET, 5, log2 I-cache line bytes; ic block address = phys addr >> IC_OFFSET
- DC_OFFSET, 4, log2 D-cache line bytes
- IC_LINE_BITS, 256, fill width (data_0..3)
- DC_LINE_BITS, 128, load return width (data_0..1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- anycoredecoder_l15_val  in  1  request valid (snooped)
- anycoredecoder_l15_rqtype  in  5  request type (IMISS_RQ/LOAD_RQ/STORE_RQ)
- anycoredecoder_l15_address  in  PHY_ADDR_WIDTH  request address
- l15_transducer_ack  in  1  L1.5 accepted the request
- l15_transducer_val  in  1  return packet valid; held until acked
- l15_transducer_returntype  in  4  LOAD_RET/IFILL_RET/ST_ACK/INT_RET/other
- l15_transducer_data_0..3  in  64 each  return payload
- transducer_l15_req_ack  out  1  return consumed (one-cycle pulse)
- anycore_mem2ic_respvalid  out  1  ifill strobe
- anycore_mem2ic_respaddr  out  ICACHE_BLOCK_ADDR_BITS  fill block address
- anycore_mem2ic_data  out  IC_LINE_BITS  fill data
- anycore_mem2dc_ldvalid  out  1  load-return strobe
- anycore_mem2dc_ldaddr  out  DCACHE_BLOCK_ADDR_BITS  load block address
- anycore_mem2dc_lddata  out  DC_LINE_BITS  load data
- anycore_mem2dc_stcomplete  out  1  store-ack strobe
- anycore_int  out  1  interrupt-return strobe
- anycore_encoder_err  out  1  sticky: return with no matching outstanding request

## Operation
- Tracker: on `anycoredecoder_l15_val & l15_transducer_ack`, set the pending bit for the request type. For imiss and load, also store the block address (address >> IC_OFFSET or >> DC_OFFSET).
- Return FSM, states IDLE and ACK:
  - IDLE: `l15_transducer_val` set → capture the packet, go to ACK.
  - ACK: pulse `transducer_l15_req_ack` and the output strobe, return to IDLE. `l15_transducer_val` is ignored in ACK so a held val is never captured twice.
- Data ordering: each 64-bit word is byte-reversed (byte 0 ↔ byte 7). Word order is data_0 in the LSBs.
- Per return type:
  - IFILL_RET: ic strobe with stored imiss address; clear imiss pending.
  - LOAD_RET: dc load strobe with stored load address and data_0..1; clear load pending.
  - ST_ACK: stcomplete; clear store pending.
  - INT_RET: anycore_int.
  - Any other type: acked, no strobe.
- Unmatched return (IFILL/LOAD/ST_ACK with its pending bit clear): still delivered with the last stored address, and anycore_encoder_err is set until reset.
- Same cycle, same type, new request ack and return capture: the return uses the old address; the pending bit ends set and the address register takes the new value (set wins over clear).

## Timing
- Reset values: all outputs 0; FSM IDLE; pending bits and address registers 0.
- Latency: val sampled in cycle N → ack and strobe in cycle N+1, both registered. Data/address outputs are valid only while their strobe is high; they hold their last value otherwise.
- Throughput: one return per 2 cycles. The earliest next capture is N+2.
- Reset asserted in ACK: no ack or strobe is emitted in the following cycle. The L1.5 retains the packet.

## Structure
- A shared package/header `anycore_l15_defs` holds:
  - return-type encodings
  - rqtype encodings (shared with the decoder)
  - the FSM state localparams
  - the byte-swap function (the decoder reuses it for store data)
- One sub-module, `anycore_req_tracker`: pending bits plus address registers, including the set/clear arbitration.

## Test plan
- Imiss to 0x0000_1040 acked, then IFILL_RET with data_0 = 0x0011223344556677:
  - ic respvalid one cycle after val
  - respaddr = 0x82
  - data[63:0] = 0x7766554433221100
  - req_ack pulses once
- Load to 0x2010 acked, then LOAD_RET held valid for 4 cycles:
  - exactly one ldvalid and one ack
  - ldaddr = 0x201
  - a second capture occurs only after val re-rises
- Store acked, then ST_ACK → stcomplete pulse, store pending clears, err stays 0.
- LOAD_RET with no load outstanding → ldvalid asserted, anycore_encoder_err = 1 and stays 1.
- Load return captured in the same cycle a new load to 0x3000 is acked:
  - delivered address is the old one
  - the next LOAD_RET returns 0x300
- rst asserted in ACK state → no ack or strobe that cycle or the next; all outputs 0.
